// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM states and stream command bytes shared by the boot loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {CMD, CNT_LO, CNT_HI, DATA, CSUM, RUN, ERR} loader_state_e;
  localparam logic [7:0] LDR_CMD_IMEM = 8'h01;
  localparam logic [7:0] LDR_CMD_DMEM = 8'h02;
  localparam logic [7:0] LDR_CMD_GO   = 8'hFF;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream valid/ready handshake feeding the program loader.
interface prog_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  modport master(output s_valid, s_data, input s_ready);
  modport slave(input s_valid, s_data, output s_ready);
endinterface

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: packs little-endian bytes into 32-bit words, flags the 4th byte.
module prog_loader_word_assembler (
  input  logic        clk,
  input  logic        rst_,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [23:0] sh;
  always_ff @(posedge clk) begin
    if (!rst_ || clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sh  <= {data, sh[23:8]};
    end
  end
  assign word_valid = en && cnt == 2'd3;
  assign word       = {data, sh};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader for cpu4 i/d memories; holds cpu in reset until GO.
// Optional per-block checksum byte enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  localparam int AW = IMEM_AW > DMEM_AW ? IMEM_AW : DMEM_AW
) (
  input  logic          clk,
  input  logic          rst_,
  prog_loader_if.slave  bus,
  output logic          imem_we,
  output logic          dmem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst_,
  output logic          done,
  output logic          error
);
  localparam logic [16:0] IDEPTH = 17'(2 ** IMEM_AW);
  localparam logic [16:0] DDEPTH = 17'(2 ** DMEM_AW);
`ifdef PROG_LOADER_CSUM_EN
  localparam loader_state_e BLK_END = CSUM;
  logic [7:0] csum;
`else
  localparam loader_state_e BLK_END = CMD;
`endif
  loader_state_e state, nxt;
  logic          xfer, tgt_imem, word_valid;
  logic [7:0]    cnt_lo;
  logic [15:0]   wcnt;
  logic [16:0]   n;
  logic [31:0]   word;
  assign bus.s_ready = state != RUN && state != ERR;
  assign xfer        = bus.s_valid && bus.s_ready;
  assign n           = {1'b0, bus.s_data, cnt_lo};
  assign cpu_rst_    = state == RUN;
  assign done        = state == RUN;
  assign error       = state == ERR;
  prog_loader_word_assembler u_word_assembler (
    .clk(clk), .rst_(rst_), .clr(state != DATA), .en(xfer && state == DATA),
    .data(bus.s_data), .word(word), .word_valid(word_valid)
  );
  always_ff @(posedge clk) begin
    if (!rst_) state <= CMD;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      CMD:    if (xfer) nxt = (bus.s_data == LDR_CMD_IMEM || bus.s_data == LDR_CMD_DMEM) ? CNT_LO :
                              bus.s_data == LDR_CMD_GO ? RUN : ERR;
      CNT_LO: if (xfer) nxt = CNT_HI;
      CNT_HI: if (xfer) nxt = n == '0 ? BLK_END : n > (tgt_imem ? IDEPTH : DDEPTH) ? ERR : DATA;
      DATA:   if (word_valid && wcnt == 16'd1) nxt = BLK_END;
`ifdef PROG_LOADER_CSUM_EN
      CSUM:   if (xfer) nxt = 8'(csum + bus.s_data) == 8'd0 ? CMD : ERR;
`endif
      default: ;
    endcase
  end
  // Strobe, address and data are registered together, so all three land one cycle after the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      tgt_imem  <= 1'b0;
      cnt_lo    <= '0;
      wcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
    end else begin
      imem_we  <= word_valid && tgt_imem;
      dmem_we  <= word_valid && !tgt_imem;
      mem_addr <= (xfer && state == CMD) ? '0 : (imem_we || dmem_we) ? mem_addr + 1'b1 : mem_addr;
      if (xfer && state == CMD) tgt_imem <= bus.s_data == LDR_CMD_IMEM;
      if (xfer && state == CNT_LO) cnt_lo <= bus.s_data;
      if (xfer && state == CNT_HI) wcnt <= n[15:0];
      else if (word_valid) wcnt <= wcnt - 16'd1;
      if (word_valid) mem_wdata <= word;
    end
  end
`ifdef PROG_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_) csum <= '0;
    else if (xfer && state == CMD) csum <= '0;
    else if (xfer && state == DATA) csum <= csum + bus.s_data;
  end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed byte-stream vectors against prog_loader, default and 4-word imem builds.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        imem_we, dmem_we, cpu_rst_, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        s_imem_we, s_dmem_we, s_cpu_rst_, s_done, s_error;
  logic [7:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  int          n_chk = 0, n_err = 0;
  int          n_imem = 0, n_dmem = 0, n_both = 0, n_small = 0;
  logic [7:0]  sum = 8'd0;
  prog_loader_if sif();
  prog_loader_if sif2();
  always #5 clk = ~clk;
  prog_loader u_dut (
    .clk(clk), .rst_(rst_), .bus(sif), .imem_we(imem_we), .dmem_we(dmem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_(cpu_rst_), .done(done), .error(error)
  );
  prog_loader #(.IMEM_AW(2)) u_small (
    .clk(clk), .rst_(rst_), .bus(sif2), .imem_we(s_imem_we), .dmem_we(s_dmem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .cpu_rst_(s_cpu_rst_), .done(s_done), .error(s_error)
  );
  always @(negedge clk) begin
    if (imem_we) n_imem++;
    if (dmem_we) n_dmem++;
    if (imem_we && dmem_we) n_both++;
    if (s_imem_we || s_dmem_we) n_small++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    sif.s_valid = 1'b1;
    sif.s_data = b;
    sif2.s_valid = 1'b1;
    sif2.s_data = b;
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    sif2.s_valid = 1'b0;
  endtask
  task automatic send_data(input logic [7:0] b);
    sum = sum + b;
    send(b);
  endtask
  task automatic blk_end;
`ifdef PROG_LOADER_CSUM_EN
    send(8'(-sum));
`endif
    sum = 8'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_ = 1'b0;
    sif.s_valid = 1'b0;
    sif2.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    sum = 8'd0;
    n_imem = 0;
    n_dmem = 0;
    n_small = 0;
  endtask
  initial begin
    sif.s_data = 8'h00;
    sif2.s_data = 8'h00;
    // reset state
    do_reset;
    chk("rst_ready", 32'(sif.s_ready), 32'd1);
    chk("rst_cpu_rst", 32'(cpu_rst_), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_we", 32'({imem_we, dmem_we}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    // two imem words then GO
    send(8'h01); send(8'h02); send(8'h00);
    send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
    chk("t1_w0_imem_we", 32'(imem_we), 32'd1);
    chk("t1_w0_dmem_we", 32'(dmem_we), 32'd0);
    chk("t1_w0_addr", 32'(mem_addr), 32'd0);
    chk("t1_w0_data", mem_wdata, 32'h00000013);
    send_data(8'h37); send_data(8'h11); send_data(8'h22); send_data(8'h44);
    chk("t1_w1_imem_we", 32'(imem_we), 32'd1);
    chk("t1_w1_addr", 32'(mem_addr), 32'd1);
    chk("t1_w1_data", mem_wdata, 32'h44221137);
    blk_end;
    chk("t1_cpu_rst_pre", 32'(cpu_rst_), 32'd0);
    send(8'hFF);
    chk("t1_cpu_rst", 32'(cpu_rst_), 32'd1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready_run", 32'(sif.s_ready), 32'd0);
    send(8'h01); send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);
    chk("t1_run_hold", 32'(done), 32'd1);
    chk("t1_imem_cnt", 32'(n_imem), 32'd2);
    chk("t1_dmem_cnt", 32'(n_dmem), 32'd0);
    // single dmem word
    do_reset;
    send(8'h02); send(8'h01); send(8'h00);
    send_data(8'hEF); send_data(8'hBE); send_data(8'hAD); send_data(8'hDE);
    chk("t2_dmem_we", 32'(dmem_we), 32'd1);
    chk("t2_imem_we", 32'(imem_we), 32'd0);
    chk("t2_addr", 32'(mem_addr), 32'd0);
    chk("t2_data", mem_wdata, 32'hDEADBEEF);
    blk_end;
    send(8'hFF);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_dmem_cnt", 32'(n_dmem), 32'd1);
    chk("t2_imem_cnt", 32'(n_imem), 32'd0);
    // illegal command
    do_reset;
    send(8'h07);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_ready", 32'(sif.s_ready), 32'd0);
    chk("t3_cpu_rst", 32'(cpu_rst_), 32'd0);
    send(8'hFF);
    idle(3);
    chk("t3_sticky", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_writes", 32'(n_imem + n_dmem), 32'd0);
    // count beyond depth on the 4-word imem instance only
    do_reset;
    send(8'h01); send(8'h05);
    chk("t4_small_err_lo", 32'(s_error), 32'd0);
    send(8'h00);
    chk("t4_small_err", 32'(s_error), 32'd1);
    chk("t4_small_ready", 32'(sif2.s_ready), 32'd0);
    chk("t4_big_err", 32'(error), 32'd0);
    send_data(8'h01); send_data(8'h02); send_data(8'h03); send_data(8'h04);
    chk("t4_big_data", mem_wdata, 32'h04030201);
    chk("t4_small_writes", 32'(n_small), 32'd0);
    // exactly 4 words fits the small imem
    do_reset;
    send(8'h01); send(8'h04); send(8'h00);
    chk("t4_fit_err", 32'(s_error), 32'd0);
    // empty block goes straight back for the next command
    do_reset;
    send(8'h01); send(8'h00); send(8'h00);
    blk_end;
    send(8'hFF);
    chk("tz_done", 32'(done), 32'd1);
    chk("tz_writes", 32'(n_imem + n_dmem), 32'd0);
`ifdef PROG_LOADER_CSUM_EN
    do_reset;
    send(8'h01); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t5_data", mem_wdata, 32'h04030201);
    send(8'hF6);
    send(8'hFF);
    chk("t5_done", 32'(done), 32'd1);
    do_reset;
    send(8'h01); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hF5);
    chk("t5_bad_err", 32'(error), 32'd1);
    send(8'hFF);
    chk("t5_bad_cpu_rst", 32'(cpu_rst_), 32'd0);
`endif
    // reset mid-word, then resend the whole block
    do_reset;
    send(8'h01); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    do_reset;
    idle(1);
    chk("t6_no_partial", 32'(n_imem + n_dmem), 32'd0);
    send(8'h01); send(8'h01); send(8'h00);
    send_data(8'hAA); send_data(8'hBB); send_data(8'hCC); send_data(8'hDD);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    chk("t6_data", mem_wdata, 32'hDDCCBBAA);
    blk_end;
    idle(2);
    chk("t6_writes", 32'(n_imem), 32'd1);
    chk("onehot_we", 32'(n_both), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
